hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline, successor to the combinational hazard unit.
//  Adds D-stage branch-operand forwarding/stall, a multicycle MDU (mul/div) stall FSM holding E for MDU_LAT cycles,
//  an M-stage bubble during MDU stalls, and a saturating stall-cycle performance counter.
//  Sits beside the datapath; drives pipeline-register enables/clears and forwarding mux selects.
// PARAMETERS
//  REG_AW    5   register-address width; register 0 is hardwired zero, never forwarded or matched
//  MDU_LAT   4   total cycles an MDU op occupies E (>=1); MDU_LAT=1 means no stall
//  PERF_W    32  width of stall-cycle counter
// PORTS
//  clka         in   1       clock, all state on rising edge
//  rst          in   1       asynchronous, active-low reset
//  rsD,rtD      in   REG_AW  source regs of instruction in D
//  useRsD,useRtD in  1       D instruction actually reads rs / rt
//  branchD      in   1       D instruction is a branch (compares in D)
//  rsE,rtE      in   REG_AW  source regs in E
//  writeregE    in   REG_AW  dest reg in E;  regwriteE, memtoregE in 1
//  mduStartE    in   1       E holds an MDU op (stays high while E is held)
//  writeregM    in   REG_AW  dest reg in M;  regwriteM, memtoregM in 1
//  writeregW    in   REG_AW  dest reg in W;  regwriteW in 1
//  perf_clr     in   1       synchronous clear of stall_cycles
//  forwardAD,forwardBD out 1      1 = take ALU result from M for D compare operand
//  forwardAE,forwardBE out 2      00 regfile, 01 W result, 10 M ALU result
//  stallF,stallD,stallE out 1     hold PC / F-D / D-E registers
//  flushE,flushM out 1            clear D-E / E-M registers (insert bubble)
//  mdu_busy     out  1       MDU FSM not IDLE
//  mdu_done     out  1       one-cycle pulse: MDU op leaves E this cycle
//  stall_cycles out  PERF_W  count of cycles with stallF=1
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, cnt=0, stall_cycles=0; all outputs forced 0 while rst=0.
//  match(a,b) = (a==b) && (a!=0).
//  forwardAE: 10 if regwriteM&match(writeregM,rsE); else 01 if regwriteW&match(writeregW,rsE); else 00. BE same with rtE. M wins over W.
//  forwardAD = regwriteM & match(writeregM,rsD); forwardBD likewise with rtD.
//  lwstall = regwriteE & memtoregE & ((useRsD&match(writeregE,rsD)) | (useRtD&match(writeregE,rtD))).
//  brstall = branchD & ( (regwriteE & (match(writeregE,rsD)|match(writeregE,rtD)))
//                      | (memtoregM & (match(writeregM,rsD)|match(writeregM,rtD))) ).
//  MDU FSM, states IDLE/BUSY, counter cnt (clog2(MDU_LAT) bits):
//   IDLE: mduStartE & MDU_LAT>=2 -> mstall=1 this cycle, cnt<=MDU_LAT-2, go BUSY.
//         mduStartE & MDU_LAT==1 -> mdu_done=1, stay IDLE.
//   BUSY: cnt!=0 -> mstall=1, cnt<=cnt-1. cnt==0 -> mstall=0, mdu_done=1, go IDLE.
//   mduStartE in BUSY is the held op, not a new start. Stall cycles per op = MDU_LAT-1; op leaves E on done cycle.
//   mdu_busy = (state==BUSY).
//  Outputs (combinational from inputs/state):
//   stallE = mstall; flushM = mstall (bubble into M while E held).
//   stallF = stallD = lwstall | brstall | mstall.
//   flushE = (lwstall | brstall) & ~mstall  (E is held, must not be cleared, during MDU stall).
//  stall_cycles: perf_clr -> 0 (priority over increment); else +1 when stallF=1; saturates at all-ones, no wrap.
//  Reset mid-MDU op: FSM returns IDLE immediately; no mdu_done pulse for the aborted op.
// TESTING
//  1 regwriteM=1,writeregM=8,rsE=8; regwriteW=1,writeregW=8 -> forwardAE=10 (M priority); writeregM=0,rsE=0 -> 00.
//  2 lw in E: regwriteE=1,memtoregE=1,writeregE=9; rsD=9,useRsD=1 -> stallF=stallD=flushE=1, stallE=0 for one cycle.
//  3 branchD=1,rtD=5, memtoregM=1,writeregM=5 -> brstall; next cycle M match with regwriteM only -> forwardBD=1, no stall.
//  4 MDU_LAT=4, mduStartE held: stallE/flushM/stallF high exactly 3 cycles, mdu_done on 4th; back-to-back ops correct.
//  5 During MDU stall assert lwstall condition -> flushE stays 0; rst low in BUSY -> IDLE, outputs 0, no done pulse.
//  6 PERF_W=4: 20 stall cycles -> stall_cycles=15 holds; perf_clr with stallF=1 -> 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard / forwarding controller for the 5-stage MIPS pipeline.
// Resolves E-stage operand forwarding, D-stage branch-operand forwarding,
// load-use and branch stalls, and holds E for multicycle MDU operations.
// It also keeps a saturating count of cycles in which fetch was stalled.
module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int PERF_W  = 32
) (
    input  logic              clka,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              useRsD,
    input  logic              useRtD,
    input  logic              branchD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              mduStartE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              perf_clr,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushE,
    output logic              flushM,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       mstall_s;
    logic       done_s;
    logic       lwstall_s;
    logic       brstall_s;
    logic       stall_any_s;
    logic [1:0] fwd_ae_s;
    logic [1:0] fwd_be_s;

    // Register 0 is hardwired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] b);
        return (a == b) && (a != {REG_AW{1'b0}});
    endfunction

    // E-stage ALU operand forwarding: the younger M result beats W.
    always_comb begin
        fwd_ae_s = 2'b00;
        fwd_be_s = 2'b00;
        if (regwriteM && reg_match(writeregM, rsE)) begin
            fwd_ae_s = 2'b10;
        end else if (regwriteW && reg_match(writeregW, rsE)) begin
            fwd_ae_s = 2'b01;
        end else begin
            fwd_ae_s = 2'b00;
        end
        if (regwriteM && reg_match(writeregM, rtE)) begin
            fwd_be_s = 2'b10;
        end else if (regwriteW && reg_match(writeregW, rtE)) begin
            fwd_be_s = 2'b01;
        end else begin
            fwd_be_s = 2'b00;
        end
    end

    // Load-use and branch-compare hazards detected against the D instruction.
    always_comb begin
        lwstall_s = regwriteE && memtoregE &&
                    ((useRsD && reg_match(writeregE, rsD)) ||
                     (useRtD && reg_match(writeregE, rtD)));
        brstall_s = branchD &&
                    ((regwriteE && (reg_match(writeregE, rsD) || reg_match(writeregE, rtD))) ||
                     (memtoregM && (reg_match(writeregM, rsD) || reg_match(writeregM, rtD))));
    end

    // MDU occupancy FSM: holds E for MDU_LAT-1 cycles, pulses done as the op leaves.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mstall_s = 1'b0;
        done_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mduStartE) begin
                    if (MDU_LAT >= 2) begin
                        mstall_s = 1'b1;
                        cnt_d    = CNT_W'(MDU_LAT - 2);
                        state_d  = BUSY;
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    mstall_s = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    done_s  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // MDU state and countdown registers.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_any_s = lwstall_s || brstall_s || mstall_s;

    // Stall-cycle counter: clear has priority, increment saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = {PERF_W{1'b0}};
        end else if (stall_any_s && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= {PERF_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output stage: every control output is held at zero while reset is asserted.
    // E is being held during an MDU stall, so it must not be flushed then.
    always_comb begin
        forwardAD    = 1'b0;
        forwardBD    = 1'b0;
        forwardAE    = 2'b00;
        forwardBE    = 2'b00;
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        mdu_busy     = 1'b0;
        mdu_done     = 1'b0;
        stall_cycles = {PERF_W{1'b0}};
        if (rst) begin
            forwardAD    = regwriteM && reg_match(writeregM, rsD);
            forwardBD    = regwriteM && reg_match(writeregM, rtD);
            forwardAE    = fwd_ae_s;
            forwardBE    = fwd_be_s;
            stallF       = stall_any_s;
            stallD       = stall_any_s;
            stallE       = mstall_s;
            flushE       = (lwstall_s || brstall_s) && !mstall_s;
            flushM       = mstall_s;
            mdu_busy     = (state_q == BUSY);
            mdu_done     = done_s;
            stall_cycles = stall_cnt_q;
        end else begin
            stall_cycles = {PERF_W{1'b0}};
        end
    end

endmodule
